decode_stage: RTL and testbench

ID stage of the ASIP pipeline, between the IF/ID pipe register and EX.
- Slices the fetched instruction and exposes opcode/funct to the control unit.
- Reads a 16-entry register file with write-through bypass from WB.
- Extends the immediate, detects load-use hazards and inserts bubbles.
- Registers all operands and control signals into the ID/EX pipe register.

---
 rtl/decode_pkg.sv | 44 ++++
 rtl/register_file.sv | 51 +++++
 rtl/decode_stage.sv | 163 ++++++++++++++++
 tb/tb_decode_stage.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: instruction field positions, immediate modes and the ID/EX pipe register layout.
package decode_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned REG_AW   = 4;

    localparam int unsigned OPC_HI   = 31;
    localparam int unsigned OPC_LO   = 29;
    localparam int unsigned FUNCT_HI = 28;
    localparam int unsigned FUNCT_LO = 27;
    localparam int unsigned RD_HI    = 26;
    localparam int unsigned RD_LO    = 23;
    localparam int unsigned RS1_HI   = 22;
    localparam int unsigned RS1_LO   = 19;
    localparam int unsigned RS2_HI   = 18;
    localparam int unsigned RS2_LO   = 15;
    localparam int unsigned IMM15_W  = 15;
    localparam int unsigned IMM19_W  = 19;

    typedef enum logic [1:0] {
        EXT_ZERO   = 2'b00,
        EXT_SIGN   = 2'b01,
        EXT_SIGN19 = 2'b10,
        EXT_UPPER  = 2'b11
    } ext_sel_t;

    typedef struct packed {
        logic                valid;
        logic [DATA_W-1:0]   pc;
        logic [DATA_W-1:0]   rs1_data;
        logic [DATA_W-1:0]   rs2_data;
        logic [DATA_W-1:0]   imm;
        logic [REG_AW-1:0]   rd;
        logic [REG_AW-1:0]   rs1;
        logic [REG_AW-1:0]   rs2;
        logic [1:0]          branch;
        logic                rb_selector;
        logic                we;
        logic                wr_en;
        logic                mem_rd;
    } id_ex_t;

endpackage

// File: rtl/register_file.sv
// register_file: 2 combinational read ports, 1 write port, write-through bypass, r0 hardwired to zero.
module register_file
    import decode_pkg::*;
#(
    parameter int unsigned N     = DATA_W,
    parameter int unsigned NREGS = NUM_REGS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] rd_addr1,
    input  logic [REG_AW-1:0] rd_addr2,
    output logic [N-1:0]      rd_data1,
    output logic [N-1:0]      rd_data2,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [N-1:0]      wr_data
);

    logic [N-1:0] r_regs [NREGS];
    logic         w_wr_ok;

    assign w_wr_ok = wr_en && (wr_addr != '0);

    // Storage: cleared on reset, written on the edge, r0 never written
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // Read ports: same-cycle WB value wins over stored contents
    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        if (w_wr_ok && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
        end else if (rd_addr1 != '0) begin
            rd_data1 = r_regs[rd_addr1];
        end
        if (w_wr_ok && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
        end else if (rd_addr2 != '0) begin
            rd_data2 = r_regs[rd_addr2];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: ID pipeline stage - field slicing, register read, immediate extension,
// load-use hazard detection and the ID/EX pipe register.
// Optional macro DECODE_STALL_CNT_EN adds a 32-bit count of hazard-bubble cycles (stall_count).
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned N     = DATA_W,
    parameter int unsigned NREGS = NUM_REGS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [N-1:0]      instruction_id,
    input  logic [N-1:0]      pc_id,
    input  logic [1:0]        branch,
    input  logic [1:0]        ext_selector,
    input  logic              rb_selector,
    input  logic              we,
    input  logic              wr_en,
    input  logic              mem_rd,
    input  logic              uses_rs2,
    input  logic              flush,
    input  logic              hold,
    input  logic              wb_we,
    input  logic [3:0]        wb_rd,
    input  logic [N-1:0]      wb_data,
    output logic [2:0]        opcode,
    output logic [1:0]        funct,
    output logic              stall,
    output logic              ex_valid,
    output logic [N-1:0]      ex_pc,
    output logic [N-1:0]      ex_rs1_data,
    output logic [N-1:0]      ex_rs2_data,
    output logic [N-1:0]      ex_imm,
    output logic [3:0]        ex_rd,
    output logic [3:0]        ex_rs1,
    output logic [3:0]        ex_rs2,
    output logic [1:0]        ex_branch,
    output logic              ex_rb_selector,
    output logic              ex_we,
    output logic              ex_wr_en,
    output logic              ex_mem_rd
`ifdef DECODE_STALL_CNT_EN
    ,
    output logic [31:0]       stall_count
`endif
);

    logic [REG_AW-1:0]  w_rd;
    logic [REG_AW-1:0]  w_rs1;
    logic [REG_AW-1:0]  w_rs2;
    logic [IMM15_W-1:0] w_imm15;
    logic [IMM19_W-1:0] w_imm19;
    logic [N-1:0]       w_imm;
    logic [N-1:0]       w_rs1_data;
    logic [N-1:0]       w_rs2_data;
    logic               w_hz;
    id_ex_t             w_dec;
    id_ex_t             r_idex;

    assign opcode  = instruction_id[OPC_HI:OPC_LO];
    assign funct   = instruction_id[FUNCT_HI:FUNCT_LO];
    assign w_rd    = instruction_id[RD_HI:RD_LO];
    assign w_rs1   = instruction_id[RS1_HI:RS1_LO];
    assign w_rs2   = instruction_id[RS2_HI:RS2_LO];
    assign w_imm15 = instruction_id[IMM15_W-1:0];
    assign w_imm19 = instruction_id[IMM19_W-1:0];

    register_file #(
        .N     (N),
        .NREGS (NREGS)
    ) u_register_file (
        .clock    (clock),
        .reset    (reset),
        .rd_addr1 (w_rs1),
        .rd_addr2 (w_rs2),
        .rd_data1 (w_rs1_data),
        .rd_data2 (w_rs2_data),
        .wr_en    (wb_we),
        .wr_addr  (wb_rd),
        .wr_data  (wb_data)
    );

    // Immediate extension selected by the control unit
    always_comb begin
        w_imm = '0;
        case (ext_sel_t'(ext_selector))
            EXT_ZERO:   w_imm = N'(w_imm15);
            EXT_SIGN:   w_imm = {{(N-IMM15_W){w_imm15[IMM15_W-1]}}, w_imm15};
            EXT_SIGN19: w_imm = {{(N-IMM19_W){w_imm19[IMM19_W-1]}}, w_imm19};
            EXT_UPPER:  w_imm = N'({w_imm15, 16'h0000});
            default:    w_imm = '0;
        endcase
    end

    // Load-use hazard against the load sitting in EX; hold and flush mask the stall
    assign w_hz  = id_valid && r_idex.valid && r_idex.mem_rd && (r_idex.rd != '0) &&
                   ((w_rs1 == r_idex.rd) || (uses_rs2 && (w_rs2 == r_idex.rd)));
    assign stall = w_hz && !flush && !hold;

    // Decoded payload; control bits are qualified by id_valid
    always_comb begin
        w_dec             = '0;
        w_dec.valid       = id_valid;
        w_dec.pc          = pc_id;
        w_dec.rs1_data    = w_rs1_data;
        w_dec.rs2_data    = w_rs2_data;
        w_dec.imm         = w_imm;
        w_dec.rd          = w_rd;
        w_dec.rs1         = w_rs1;
        w_dec.rs2         = w_rs2;
        w_dec.branch      = branch & {2{id_valid}};
        w_dec.rb_selector = rb_selector & id_valid;
        w_dec.we          = we & id_valid;
        w_dec.wr_en       = wr_en & id_valid;
        w_dec.mem_rd      = mem_rd & id_valid;
    end

    // ID/EX pipe register: reset > flush > hold > hazard bubble > load
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_idex <= '0;
        end else if (flush) begin
            r_idex <= '0;
        end else if (hold) begin
            r_idex <= r_idex;
        end else if (w_hz) begin
            r_idex <= '0;
        end else begin
            r_idex <= w_dec;
        end
    end

`ifdef DECODE_STALL_CNT_EN
    logic [31:0] r_stall_count;

    // Counts cycles in which a hazard bubble is inserted; wraps naturally
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_stall_count <= '0;
        end else if (!flush && !hold && w_hz) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

    assign ex_valid       = r_idex.valid;
    assign ex_pc          = r_idex.pc;
    assign ex_rs1_data    = r_idex.rs1_data;
    assign ex_rs2_data    = r_idex.rs2_data;
    assign ex_imm         = r_idex.imm;
    assign ex_rd          = r_idex.rd;
    assign ex_rs1         = r_idex.rs1;
    assign ex_rs2         = r_idex.rs2;
    assign ex_branch      = r_idex.branch;
    assign ex_rb_selector = r_idex.rb_selector;
    assign ex_we          = r_idex.we;
    assign ex_wr_en       = r_idex.wr_en;
    assign ex_mem_rd      = r_idex.mem_rd;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed stimulus with a queue-based scoreboard checked by a negedge monitor.
module tb_decode_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [1:0]  branch;
        logic        rb;
        logic        we;
        logic        wr_en;
        logic        mem_rd;
    } ex_t;

    typedef struct packed {
        logic       stall;
        logic [2:0] opcode;
        logic [1:0] funct;
        ex_t        ex;
    } obs_t;

    logic        clock;
    logic        reset;
    logic        id_valid;
    logic [31:0] instruction_id;
    logic [31:0] pc_id;
    logic [1:0]  branch;
    logic [1:0]  ext_selector;
    logic        rb_selector;
    logic        we;
    logic        wr_en;
    logic        mem_rd;
    logic        uses_rs2;
    logic        flush;
    logic        hold;
    logic        wb_we;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic [2:0]  opcode;
    logic [1:0]  funct;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [31:0] ex_imm;
    logic [3:0]  ex_rd;
    logic [3:0]  ex_rs1;
    logic [3:0]  ex_rs2;
    logic [1:0]  ex_branch;
    logic        ex_rb_selector;
    logic        ex_we;
    logic        ex_wr_en;
    logic        ex_mem_rd;
`ifdef DECODE_STALL_CNT_EN
    logic [31:0] stall_count;
`endif

    int   checks;
    int   errors;
    int   cycle;
    obs_t exp_q[$];

    decode_stage dut (
        .clock          (clock),
        .reset          (reset),
        .id_valid       (id_valid),
        .instruction_id (instruction_id),
        .pc_id          (pc_id),
        .branch         (branch),
        .ext_selector   (ext_selector),
        .rb_selector    (rb_selector),
        .we             (we),
        .wr_en          (wr_en),
        .mem_rd         (mem_rd),
        .uses_rs2       (uses_rs2),
        .flush          (flush),
        .hold           (hold),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .opcode         (opcode),
        .funct          (funct),
        .stall          (stall),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_rs1_data    (ex_rs1_data),
        .ex_rs2_data    (ex_rs2_data),
        .ex_imm         (ex_imm),
        .ex_rd          (ex_rd),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_branch      (ex_branch),
        .ex_rb_selector (ex_rb_selector),
        .ex_we          (ex_we),
        .ex_wr_en       (ex_wr_en),
        .ex_mem_rd      (ex_mem_rd)
`ifdef DECODE_STALL_CNT_EN
        ,
        .stall_count    (stall_count)
`endif
    );

    initial begin
        clock = 1'b1;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] enc(input logic [2:0] op, input logic [1:0] fn,
                                        input logic [3:0] rd, input logic [3:0] rs1,
                                        input logic [3:0] rs2, input logic [14:0] imm15);
        return {op, fn, rd, rs1, rs2, imm15};
    endfunction

    function automatic ex_t mk(input logic v, input logic [31:0] pc, input logic [3:0] rd,
                               input logic [3:0] rs1, input logic [3:0] rs2,
                               input logic [31:0] d1, input logic [31:0] d2,
                               input logic [31:0] imm, input logic [1:0] br,
                               input logic rb, input logic w, input logic wm, input logic mr);
        ex_t e;
        e.valid = v;    e.pc = pc;       e.rd = rd;     e.rs1 = rs1;  e.rs2 = rs2;
        e.rs1_data = d1; e.rs2_data = d2; e.imm = imm;  e.branch = br;
        e.rb = rb;      e.we = w;        e.wr_en = wm;  e.mem_rd = mr;
        return e;
    endfunction

    // Push the outputs expected during this cycle, then advance one clock edge
    task automatic step(input logic exp_stall, input ex_t e);
        obs_t o;
        o.stall  = exp_stall;
        o.opcode = instruction_id[31:29];
        o.funct  = instruction_id[28:27];
        o.ex     = e;
        exp_q.push_back(o);
        @(posedge clock);
        #1;
    endtask

    task automatic ctrl(input logic [1:0] br, input logic [1:0] ext, input logic rb,
                        input logic w, input logic wm, input logic mr, input logic u2);
        branch = br; ext_selector = ext; rb_selector = rb;
        we = w; wr_en = wm; mem_rd = mr; uses_rs2 = u2;
    endtask

    // Monitor: compare every presented cycle against the scoreboard head
    always @(negedge clock) begin
        obs_t act;
        obs_t e;
        cycle <= cycle + 1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act.stall  = stall;
            act.opcode = opcode;
            act.funct  = funct;
            act.ex     = mk(ex_valid, ex_pc, ex_rd, ex_rs1, ex_rs2, ex_rs1_data, ex_rs2_data,
                            ex_imm, ex_branch, ex_rb_selector, ex_we, ex_wr_en, ex_mem_rd);
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL obs cycle %0d: got %h expected %h", cycle, act, e);
            end
        end
    end

    ex_t z, x1, x2, x3, x4, x5, x6, x7, x8, x9, x10, x11, x12;

    initial begin
        checks = 0; errors = 0; cycle = 0;
        z = '0;
        reset = 1'b0; id_valid = 1'b1; flush = 1'b0; hold = 1'b0;
        wb_we = 1'b0; wb_rd = 4'd0; wb_data = 32'd0;
        instruction_id = 32'h2088_0005; pc_id = 32'h100;
        ctrl(2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clock); #1;

        // Reset held with a valid instruction present
        step(1'b0, z);
        reset = 1'b1;
        step(1'b0, z);
        x1 = mk(1'b1, 32'h100, 4'd1, 4'd1, 4'd0, 32'd0, 32'd0, 32'd5, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Same-cycle WB of r3 bypassed into the rs1 read
        instruction_id = enc(3'd0, 2'd0, 4'd2, 4'd3, 4'd0, 15'd0); pc_id = 32'h104;
        ctrl(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wb_we = 1'b1; wb_rd = 4'd3; wb_data = 32'hDEAD_BEEF;
        step(1'b0, x1);
        x2 = mk(1'b1, 32'h104, 4'd2, 4'd3, 4'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Write to r0 is neither stored nor bypassed
        instruction_id = enc(3'd0, 2'd0, 4'd4, 4'd0, 4'd0, 15'd0); pc_id = 32'h108;
        wb_we = 1'b1; wb_rd = 4'd0; wb_data = 32'h1234;
        step(1'b0, x2);
        x3 = mk(1'b1, 32'h108, 4'd4, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // r0 again, r3 from storage, sign-extended imm15
        instruction_id = enc(3'd0, 2'd0, 4'd6, 4'd0, 4'd3, 15'h4000); pc_id = 32'h10C;
        ctrl(2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wb_we = 1'b0;
        step(1'b0, x3);
        x4 = mk(1'b1, 32'h10C, 4'd6, 4'd0, 4'd3, 32'd0, 32'hDEAD_BEEF, 32'hFFFF_C000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Load to r5
        instruction_id = enc(3'd4, 2'd0, 4'd5, 4'd3, 4'd0, 15'd8); pc_id = 32'h110;
        ctrl(2'b00, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, x4);
        x5 = mk(1'b1, 32'h110, 4'd5, 4'd3, 4'd0, 32'hDEAD_BEEF, 32'd0, 32'd8, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1);

        // Consumer of r5 via rs2: one stall cycle, then a bubble in EX
        instruction_id = enc(3'd0, 2'd1, 4'd6, 4'd1, 4'd5, 15'd0); pc_id = 32'h114;
        ctrl(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, x5);
        wb_we = 1'b1; wb_rd = 4'd5; wb_data = 32'hCAFE_0005;
        step(1'b0, z);
        x6 = mk(1'b1, 32'h114, 4'd6, 4'd1, 4'd5, 32'd0, 32'hCAFE_0005, 32'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef DECODE_STALL_CNT_EN
        checks++;
        if (stall_count !== 32'd1) begin
            errors++;
            $display("FAIL stall_count: got %0d expected 1", stall_count);
        end
`endif

        // Load to r7, then dependent instruction with flush asserted
        instruction_id = enc(3'd4, 2'd0, 4'd7, 4'd0, 4'd0, 15'h7FFF); pc_id = 32'h118;
        ctrl(2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        wb_we = 1'b0;
        step(1'b0, x6);
        x7 = mk(1'b1, 32'h118, 4'd7, 4'd0, 4'd0, 32'd0, 32'd0, 32'h0000_7FFF, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
        instruction_id = enc(3'd0, 2'd0, 4'd1, 4'd7, 4'd0, 15'd0); pc_id = 32'h11C;
        ctrl(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        step(1'b0, x7);
        flush = 1'b0;

        // Branch with sign-extended imm19
        instruction_id = enc(3'd5, 2'd2, 4'd8, 4'd2, 4'd8, 15'd1); pc_id = 32'h120;
        ctrl(2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, z);
        x8 = mk(1'b1, 32'h120, 4'd8, 4'd2, 4'd8, 32'd0, 32'd0, 32'hFFFC_0001, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);

        // Hold for three cycles freezes ID/EX, then upper immediate loads
        instruction_id = enc(3'd6, 2'd3, 4'd9, 4'd0, 4'd0, 15'h1234); pc_id = 32'h124;
        ctrl(2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, x8);
        hold = 1'b0;
        step(1'b0, x8);
        x9 = mk(1'b1, 32'h124, 4'd9, 4'd0, 4'd0, 32'd0, 32'd0, 32'h1234_0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);

        // Invalid slot: data fields load, controls masked
        id_valid = 1'b0;
        instruction_id = enc(3'd0, 2'd0, 4'd10, 4'd3, 4'd0, 15'd2); pc_id = 32'h128;
        ctrl(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, x9);
        x10 = mk(1'b0, 32'h128, 4'd10, 4'd3, 4'd0, 32'hDEAD_BEEF, 32'd0, 32'd2, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Load to r11, consumer stalls, reset lands during the stall
        id_valid = 1'b1;
        instruction_id = enc(3'd4, 2'd0, 4'd11, 4'd0, 4'd0, 15'd0); pc_id = 32'h12C;
        ctrl(2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, x10);
        x11 = mk(1'b1, 32'h12C, 4'd11, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
        instruction_id = enc(3'd0, 2'd0, 4'd12, 4'd11, 4'd3, 15'd0); pc_id = 32'h130;
        ctrl(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step(1'b1, x11);
        reset = 1'b1;
        step(1'b0, z);
        x12 = mk(1'b1, 32'h130, 4'd12, 4'd11, 4'd3, 32'd0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        id_valid = 1'b0; instruction_id = 32'd0; pc_id = 32'd0;
        step(1'b0, x12);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
